// File: rtl/train_move_sequencer_if.sv
// Control/status bundle between user logic (master) and the train move sequencer (slave).
// With TRAIN_SEQ_PAUSE_EN defined the bundle also carries the pause request.
interface train_move_sequencer_if;
  logic        start;
  logic        stop;
  logic        dir;
  logic        len_sel;
  logic        loop;
`ifdef TRAIN_SEQ_PAUSE_EN
  logic        pause;
`endif
  logic        act_D;
  logic [15:0] addr16;
  logic [3:0]  pos;
  logic        busy;
  logic        done;

`ifdef TRAIN_SEQ_PAUSE_EN
  modport master (output start, stop, dir, len_sel, loop, pause,
                  input  act_D, addr16, pos, busy, done);
  modport slave  (input  start, stop, dir, len_sel, loop, pause,
                  output act_D, addr16, pos, busy, done);
`else
  modport master (output start, stop, dir, len_sel, loop,
                  input  act_D, addr16, pos, busy, done);
  modport slave  (input  start, stop, dir, len_sel, loop,
                  output act_D, addr16, pos, busy, done);
`endif
endinterface

// File: rtl/train_move_sequencer.sv
// Steps a 2- or 4-wide droplet train across 10 electrodes, emitting nibble position codes.
// Optional TRAIN_SEQ_PAUSE_EN adds a pause input that freezes the dwell while holding the code.
module train_move_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input logic                   clock,
  input logic                   reset,
  train_move_sequencer_if.slave bus
);

  localparam logic [1:0]       IDLE    = 2'd0;
  localparam logic [1:0]       HOLD    = 2'd1;
  localparam logic [1:0]       DONE    = 2'd2;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       pos_reg, pos_next;
  logic [15:0]      addr_reg, addr_next;
  logic             act_reg, act_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             stop_reg, stop_next;
  logic             dir_reg, dir_next;
  logic             wide_reg, wide_next;
  logic             loop_reg, loop_next;

  logic             paused;
  logic             stop_seen;
  logic             at_end;
  logic             finish;
  logic [3:0]       first_pos;
  logic [3:0]       fwd_pos;
  logic [3:0]       rev_pos;

  // Unused nibbles of a 2-wide code are 4'hF, which the generator decodes as "no electrode".
  function automatic logic [15:0] code_of(input logic [3:0] k, input logic wide);
    if (wide)
      code_of = {k, k + 4'd1, k + 4'd2, k + 4'd3};
    else
      code_of = {k, k + 4'd1, 4'hF, 4'hF};
  endfunction

  function automatic logic [3:0] max_of(input logic wide);
    max_of = wide ? 4'd6 : 4'd8;
  endfunction

`ifdef TRAIN_SEQ_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pos_next   = pos_reg;
    addr_next  = addr_reg;
    act_next   = act_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    stop_next  = stop_reg;
    dir_next   = dir_reg;
    wide_next  = wide_reg;
    loop_next  = loop_reg;
    finish     = 1'b0;
    stop_seen  = stop_reg | bus.stop;
    first_pos  = bus.dir ? max_of(bus.len_sel) : 4'd0;
    fwd_pos    = pos_reg + 4'd1;
    rev_pos    = pos_reg - 4'd1;
    at_end     = dir_reg ? (pos_reg == 4'd0) : (pos_reg == max_of(wide_reg));

    case (state_reg)
      IDLE: begin
        act_next  = 1'b0;
        addr_next = 16'h0000;
        busy_next = 1'b0;
        if (bus.start) begin
          dir_next   = bus.dir;
          wide_next  = bus.len_sel;
          loop_next  = bus.loop;
          pos_next   = first_pos;
          addr_next  = code_of(first_pos, bus.len_sel);
          act_next   = 1'b1;
          busy_next  = 1'b1;
          cnt_next   = RELOAD;
          stop_next  = bus.stop;
          state_next = HOLD;
        end
      end

      HOLD: begin
        // A stop seen while paused is remembered and honoured at the next boundary.
        stop_next = stop_seen;
        if (!paused) begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
          end else if (stop_seen) begin
            finish = 1'b1;
          end else if (!at_end) begin
            pos_next  = dir_reg ? rev_pos : fwd_pos;
            addr_next = code_of(pos_next, wide_reg);
            cnt_next  = RELOAD;
          end else if (loop_reg) begin
            // Bounce: the end position is shown once, then step back the way we came.
            dir_next  = ~dir_reg;
            pos_next  = dir_reg ? fwd_pos : rev_pos;
            addr_next = code_of(pos_next, wide_reg);
            cnt_next  = RELOAD;
          end else begin
            finish = 1'b1;
          end
        end
        if (finish) begin
          state_next = DONE;
          act_next   = 1'b0;
          addr_next  = 16'h0000;
          done_next  = 1'b1;
          stop_next  = 1'b0;
        end
      end

      DONE: begin
        state_next = IDLE;
        act_next   = 1'b0;
        addr_next  = 16'h0000;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pos_reg   <= 4'd0;
      addr_reg  <= 16'h0000;
      act_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      stop_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      wide_reg  <= 1'b0;
      loop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pos_reg   <= pos_next;
      addr_reg  <= addr_next;
      act_reg   <= act_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      stop_reg  <= stop_next;
      dir_reg   <= dir_next;
      wide_reg  <= wide_next;
      loop_reg  <= loop_next;
    end
  end

  assign bus.act_D  = act_reg;
  assign bus.addr16 = addr_reg;
  assign bus.pos    = pos_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule
